// File: rtl/uart_cmd_frame_tx.sv
// uart_cmd_frame_tx: command framer + UART serializer feeding UART_RX_IN.
// Outputs are registered from next-state so they line up with state changes.
module uart_cmd_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4,
    parameter int BIT_DIV    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VLD,
    output logic                  CMD_RDY,
    input  logic [1:0]            CMD_TYPE,
    input  logic [RF_ADDR-1:0]    CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_DATA,
    input  logic [DATA_WIDTH-1:0] CMD_OPB,
    input  logic [3:0]            CMD_FUN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DONE
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    localparam logic [7:0] BAUD_TC = 8'(BIT_DIV - 1);
    localparam logic [2:0] BIT_TC  = 3'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_ALN = DATA_WIDTH'(8'hDD);

    state_e                state_q, state_d;
    logic [7:0]            baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [1:0]            byte_q, byte_d;
    logic [1:0]            type_q;
    logic [RF_ADDR-1:0]    addr_q;
    logic [DATA_WIDTH-1:0] data_q, opb_q;
    logic [3:0]            fun_q;
    logic                  par_en_q, par_typ_q;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  rdy_q, rdy_d;
    logic                  done_q, done_d;

    logic                  accept, tick, last_byte;
    logic [1:0]            last_idx;
    logic [DATA_WIDTH-1:0] byte_sel;
    logic [DATA_WIDTH-1:0] addr_x, fun_x;

    assign accept = CMD_VLD && rdy_q;
    assign tick   = (baud_q == BAUD_TC);
    assign addr_x = DATA_WIDTH'(addr_q);
    assign fun_x  = DATA_WIDTH'(fun_q);

    always_comb begin
        last_idx = 2'd1;
        unique case (type_q)
            2'd0:    last_idx = 2'd2;
            2'd2:    last_idx = 2'd3;
            default: last_idx = 2'd1;
        endcase
    end

    assign last_byte = (byte_q == last_idx);

    // State register and command latch
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            type_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            opb_q     <= '0;
            fun_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            if (accept) begin
                type_q    <= CMD_TYPE;
                addr_q    <= CMD_ADDR;
                data_q    <= CMD_DATA;
                opb_q     <= CMD_OPB;
                fun_q     <= CMD_FUN;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        if (state_q != S_IDLE) begin
            baud_d = tick ? 8'd0 : baud_q + 8'd1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == BIT_TC) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick) begin
                    if (last_byte) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte on the wire for the upcoming state
    always_comb begin
        byte_sel = '0;
        unique case (type_q)
            2'd0: begin
                unique case (byte_d)
                    2'd0:    byte_sel = HDR_WR;
                    2'd1:    byte_sel = addr_x;
                    default: byte_sel = data_q;
                endcase
            end
            2'd1: byte_sel = (byte_d == 2'd0) ? HDR_RD : addr_x;
            2'd2: begin
                unique case (byte_d)
                    2'd0:    byte_sel = HDR_ALU;
                    2'd1:    byte_sel = data_q;
                    2'd2:    byte_sel = opb_q;
                    default: byte_sel = fun_x;
                endcase
            end
            default: byte_sel = (byte_d == 2'd0) ? HDR_ALN : fun_x;
        endcase
    end

    // Output logic
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = byte_sel[bit_d];
            S_PARITY: tx_d = (^byte_sel) ^ par_typ_q;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        rdy_d  = (state_d == S_IDLE);
        done_d = (state_q == S_STOP) && tick && last_byte;
    end

    assign TX_OUT  = tx_q;
    assign BUSY    = busy_q;
    assign CMD_RDY = rdy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// tb_uart_cmd_frame_tx: directed frame checks for uart_cmd_frame_tx.
// Decodes each UART frame off the line and compares with hand-built values.
module tb_uart_cmd_frame_tx;

    localparam int BD = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CMD_VLD = 1'b0;
    logic       CMD_RDY;
    logic [1:0] CMD_TYPE = '0;
    logic [3:0] CMD_ADDR = '0;
    logic [7:0] CMD_DATA = '0;
    logic [7:0] CMD_OPB = '0;
    logic [3:0] CMD_FUN = '0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       BUSY;
    logic       DONE;

    int n_chk = 0;
    int n_err = 0;

    uart_cmd_frame_tx #(
        .DATA_WIDTH(8),
        .RF_ADDR(4),
        .BIT_DIV(BD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .CMD_VLD(CMD_VLD),
        .CMD_RDY(CMD_RDY),
        .CMD_TYPE(CMD_TYPE),
        .CMD_ADDR(CMD_ADDR),
        .CMD_DATA(CMD_DATA),
        .CMD_OPB(CMD_OPB),
        .CMD_FUN(CMD_FUN),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .TX_OUT(TX_OUT),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(
        input string       tag,
        input logic [1:0]  ty,
        input logic [3:0]  ad,
        input logic [7:0]  da,
        input logic [7:0]  ob,
        input logic [3:0]  fn,
        input logic        pen,
        input logic        pty,
        input int          nb,
        input logic [31:0] bytes,
        input logic [3:0]  pars,
        input int          exp_cyc,
        input bit          hold,
        input bit          disturb,
        input logic [3:0]  next_fun
    );
        int nbits;
        int glitch;
        int busy_cnt;
        int done_cnt;
        int cyc;
        logic [10:0] obs;
        logic [10:0] expf;
        @(negedge CLK);
        CMD_TYPE = ty;
        CMD_ADDR = ad;
        CMD_DATA = da;
        CMD_OPB  = ob;
        CMD_FUN  = fn;
        PAR_EN   = pen;
        PAR_TYP  = pty;
        CMD_VLD  = 1'b1;
        check({tag, "_rdy"}, 32'(CMD_RDY), 32'd1);
        @(posedge CLK);
        #1;
        if (hold) CMD_FUN = next_fun;
        else CMD_VLD = 1'b0;
        nbits = pen ? 11 : 10;
        glitch = 0;
        busy_cnt = 0;
        done_cnt = 0;
        cyc = 0;
        for (int b = 0; b < nb; b++) begin
            obs = '1;
            expf = '1;
            expf[0] = 1'b0;
            expf[8:1] = bytes[8*b +: 8];
            if (pen) expf[9] = pars[b];
            for (int j = 0; j < nbits; j++) begin
                obs[j] = TX_OUT;
                for (int c = 0; c < BD; c++) begin
                    if (TX_OUT !== obs[j]) glitch++;
                    if (BUSY === 1'b1) busy_cnt++;
                    if (DONE === 1'b1) done_cnt++;
                    cyc++;
                    if (disturb && cyc == 20) begin
                        CMD_TYPE = ~CMD_TYPE;
                        CMD_DATA = ~CMD_DATA;
                        CMD_VLD  = 1'b1;
                    end
                    if (disturb && cyc == 21) CMD_VLD = 1'b0;
                    @(posedge CLK);
                    #1;
                end
            end
            check($sformatf("%s_byte%0d", tag, b), 32'(obs), 32'(expf));
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc));
        check({tag, "_bit_stable"}, 32'(glitch), 32'd0);
        check({tag, "_no_early_done"}, 32'(done_cnt), 32'd0);
        check({tag, "_done"}, 32'(DONE), 32'd1);
        check({tag, "_end_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_end_rdy"}, 32'(CMD_RDY), 32'd1);
        check({tag, "_end_tx"}, 32'(TX_OUT), 32'd1);
        if (!hold) begin
            @(posedge CLK);
            #1;
            check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
            check({tag, "_no_extra"}, 32'(BUSY), 32'd0);
        end
    endtask

    initial begin
        int dcnt;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_rdy", 32'(CMD_RDY), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("rel_rdy", 32'(CMD_RDY), 32'd1);

        run_cmd("wr", 2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0,
                3, 32'h003C05AA, 4'b0000, 120, 1'b0, 1'b0, 4'h0);
        run_cmd("rd_odd", 2'd1, 4'h7, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1,
                2, 32'h000007BB, 4'b0001, 88, 1'b0, 1'b0, 4'h0);
        run_cmd("alu", 2'd2, 4'h0, 8'h12, 8'h34, 4'h2, 1'b0, 1'b0,
                4, 32'h023412CC, 4'b0000, 160, 1'b0, 1'b0, 4'h0);
        run_cmd("alu_even", 2'd2, 4'h0, 8'h0F, 8'h01, 4'hF, 1'b1, 1'b0,
                4, 32'h0F010FCC, 4'b0100, 176, 1'b0, 1'b0, 4'h0);
        run_cmd("b2b_a", 2'd3, 4'h0, 8'h00, 8'h00, 4'h1, 1'b0, 1'b0,
                2, 32'h000001DD, 4'b0000, 80, 1'b1, 1'b0, 4'h8);
        run_cmd("b2b_b", 2'd3, 4'h0, 8'h00, 8'h00, 4'h8, 1'b0, 1'b0,
                2, 32'h000008DD, 4'b0000, 80, 1'b0, 1'b0, 4'h0);
        run_cmd("busy_ign", 2'd0, 4'h9, 8'h5A, 8'h00, 4'h0, 1'b0, 1'b0,
                3, 32'h005A09AA, 4'b0000, 120, 1'b0, 1'b1, 4'h0);

        @(negedge CLK);
        CMD_TYPE = 2'd0;
        CMD_ADDR = 4'h3;
        CMD_DATA = 8'h81;
        PAR_EN   = 1'b0;
        CMD_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VLD = 1'b0;
        repeat (50) @(posedge CLK);
        #1;
        check("mid_busy", 32'(BUSY), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("mrst_tx", 32'(TX_OUT), 32'd1);
        check("mrst_busy", 32'(BUSY), 32'd0);
        check("mrst_rdy", 32'(CMD_RDY), 32'd0);
        check("mrst_done", 32'(DONE), 32'd0);
        @(posedge CLK);
        #1;
        check("mrst_rdy2", 32'(CMD_RDY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("mrel_rdy", 32'(CMD_RDY), 32'd1);
        check("mrel_tx", 32'(TX_OUT), 32'd1);
        dcnt = 0;
        for (int i = 0; i < 130; i++) begin
            if (DONE === 1'b1 || BUSY === 1'b1) dcnt++;
            @(posedge CLK);
            #1;
        end
        check("mrst_no_done", 32'(dcnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
